// File: rtl/int_exec_unit_if.sv
// Issue/writeback bundle between the operand fetch, the execute stage and the register file write port.
interface int_exec_unit_if #(
  parameter int DW = 16
);
  logic          start;
  logic [3:0]    op;
  logic [2:0]    dest;
  logic [DW-1:0] R;
  logic [DW-1:0] S;
  logic          busy;
  logic          we;
  logic [2:0]    W_Adr;
  logic [DW-1:0] W;
  logic          N;
  logic          Z;
  logic          C;
  logic          V;
  logic          err;

  modport master (
    output start, op, dest, R, S,
    input  busy, we, W_Adr, W, N, Z, C, V, err
  );

  modport slave (
    input  start, op, dest, R, S,
    output busy, we, W_Adr, W, N, Z, C, V, err
  );
endinterface

// File: rtl/int_exec_unit.sv
// Integer execute stage: single-cycle ALU ops plus iterative shift-add multiply and restoring divide.
// Define INT_EXEC_UNIT_DIV_EN to build the divider (opcode A); otherwise opcode A is illegal.
module int_exec_unit #(
  parameter int DW = 16
) (
  input  logic           clk,
  input  logic           reset,
  int_exec_unit_if.slave bus
);
  localparam int CW = $clog2(DW) + 1;

  localparam logic [3:0] OP_PASS = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_MUL  = 4'h9;
`ifdef INT_EXEC_UNIT_DIV_EN
  localparam logic [3:0] OP_DIV  = 4'hA;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
`ifdef INT_EXEC_UNIT_DIV_EN
    DIV  = 2'd2,
`endif
    WB   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  // hi/lo hold product or remainder/quotient; b holds multiplicand or divisor.
  logic [DW-1:0] hi, lo, b;

  logic [DW:0]   alu_wide;
  logic [DW-1:0] alu_res;
  logic          alu_c, alu_v, legal, iterate;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    alu_wide = '0;
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    legal    = 1'b1;
    iterate  = 1'b0;
    case (bus.op)
      OP_PASS: alu_res = bus.R;
      OP_ADD: begin
        alu_wide = {1'b0, bus.R} + {1'b0, bus.S};
        alu_res  = alu_wide[DW-1:0];
        alu_c    = alu_wide[DW];
        alu_v    = (bus.R[DW-1] == bus.S[DW-1]) && (alu_res[DW-1] != bus.R[DW-1]);
      end
      OP_SUB: begin
        alu_wide = {1'b0, bus.R} - {1'b0, bus.S};
        alu_res  = alu_wide[DW-1:0];
        alu_c    = alu_wide[DW];
        alu_v    = (bus.R[DW-1] != bus.S[DW-1]) && (alu_res[DW-1] != bus.R[DW-1]);
      end
      OP_AND: alu_res = bus.R & bus.S;
      OP_OR:  alu_res = bus.R | bus.S;
      OP_XOR: alu_res = bus.R ^ bus.S;
      OP_NOT: alu_res = ~bus.R;
      OP_SHL: begin
        alu_res = {bus.R[DW-2:0], 1'b0};
        alu_c   = bus.R[DW-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, bus.R[DW-1:1]};
        alu_c   = bus.R[0];
      end
      OP_MUL: iterate = 1'b1;
`ifdef INT_EXEC_UNIT_DIV_EN
      OP_DIV: begin
        // Divide by zero skips the iterations and writes back the saturated quotient.
        iterate = (bus.S != '0);
        alu_res = '1;
        alu_v   = 1'b1;
      end
`endif
      default: legal = 1'b0;
    endcase
  end

  logic [DW:0]   mul_sum;
  logic [DW-1:0] it_hi, it_lo;
  logic          fin_v;
`ifdef INT_EXEC_UNIT_DIV_EN
  logic [DW:0]   div_shift, div_diff;
`endif

  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    it_hi   = mul_sum[DW:1];
    it_lo   = {mul_sum[0], lo[DW-1:1]};
`ifdef INT_EXEC_UNIT_DIV_EN
    div_shift = {hi, lo[DW-1]};
    div_diff  = div_shift - {1'b0, b};
    if (state == DIV) begin
      // A negative trial difference restores the shifted remainder and shifts in a 0.
      if (div_diff[DW]) begin
        it_hi = div_shift[DW-1:0];
        it_lo = {lo[DW-2:0], 1'b0};
      end else begin
        it_hi = div_diff[DW-1:0];
        it_lo = {lo[DW-2:0], 1'b1};
      end
    end
    fin_v = (state == MUL) && (|it_hi);
`else
    fin_v = |it_hi;
`endif
  end

  // NOTE: all sequential state uses nonblocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the iteration scratch registers are reset along with the visible state; it is cheap and keeps X out.
      state     <= IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      b         <= '0;
      bus.busy  <= 1'b0;
      bus.we    <= 1'b0;
      bus.err   <= 1'b0;
      bus.W_Adr <= '0;
      bus.W     <= '0;
      bus.N     <= 1'b0;
      bus.Z     <= 1'b0;
      bus.C     <= 1'b0;
      bus.V     <= 1'b0;
    end else begin
      bus.we  <= 1'b0;
      bus.err <= 1'b0;
      case (state)
        IDLE, WB: begin
          state <= IDLE;
          if (bus.start) begin
            if (!legal) begin
              bus.err <= 1'b1;
            end else if (iterate) begin
              bus.busy  <= 1'b1;
              bus.W_Adr <= bus.dest;
              cnt       <= '0;
              hi        <= '0;
`ifdef INT_EXEC_UNIT_DIV_EN
              if (bus.op == OP_DIV) begin
                state <= DIV;
                lo    <= bus.R;
                b     <= bus.S;
              end else begin
                state <= MUL;
                lo    <= bus.S;
                b     <= bus.R;
              end
`else
              state <= MUL;
              lo    <= bus.S;
              b     <= bus.R;
`endif
            end else begin
              state     <= WB;
              bus.we    <= 1'b1;
              bus.W_Adr <= bus.dest;
              bus.W     <= alu_res;
              bus.N     <= alu_res[DW-1];
              bus.Z     <= (alu_res == '0);
              bus.C     <= alu_c;
              bus.V     <= alu_v;
            end
          end
        end
`ifdef INT_EXEC_UNIT_DIV_EN
        MUL, DIV: begin
`else
        MUL: begin
`endif
          hi  <= it_hi;
          lo  <= it_lo;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DW - 1)) begin
            state    <= WB;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.we   <= 1'b1;
            bus.W    <= it_lo;
            bus.N    <= it_lo[DW-1];
            bus.Z    <= (it_lo == '0);
            bus.C    <= 1'b0;
            bus.V    <= fin_v;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_int_exec_unit.sv
// Randomized self-checking bench for int_exec_unit against an arithmetic reference model.
module tb_int_exec_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  logic sh_n = 1'b0, sh_z = 1'b0, sh_c = 1'b0, sh_v = 1'b0;

  int_exec_unit_if #(.DW(16)) bus ();
  int_exec_unit #(.DW(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected result from plain integer arithmetic; lat is cycles from accept to the we/err cycle.
  function automatic void ref_model(input logic [3:0] op, input logic [15:0] r, input logic [15:0] s,
                                    output logic [15:0] w, output logic c, output logic v,
                                    output bit legal, output int lat);
    int sr;
    int unsigned prod;
    w = '0; c = 1'b0; v = 1'b0; legal = 1'b1; lat = 1;
    case (op)
      4'h0: w = r;
      4'h1: begin
        prod = int'(r) + int'(s);
        w = prod[15:0];
        c = prod > 32'hFFFF;
        sr = int'($signed(r)) + int'($signed(s));
        v = (sr > 32767) || (sr < -32768);
      end
      4'h2: begin
        w = r - s;
        c = r < s;
        sr = int'($signed(r)) - int'($signed(s));
        v = (sr > 32767) || (sr < -32768);
      end
      4'h3: w = r & s;
      4'h4: w = r | s;
      4'h5: w = r ^ s;
      4'h6: w = ~r;
      4'h7: begin w = r * 2; c = r >= 16'h8000; end
      4'h8: begin w = r / 2; c = r % 2 == 1; end
      4'h9: begin
        prod = int'(r) * int'(s);
        w = prod[15:0];
        v = (prod >> 16) != 0;
        lat = 17;
      end
`ifdef INT_EXEC_UNIT_DIV_EN
      4'hA: begin
        if (s == 0) begin
          w = 16'hFFFF;
          v = 1'b1;
        end else begin
          w = r / s;
          lat = 17;
        end
      end
`endif
      default: legal = 1'b0;
    endcase
  endfunction

  task automatic expect_wb(input string tag, input logic [2:0] dest, input logic [15:0] w,
                           input logic c, input logic v);
    check({tag, ".we"}, bus.we, 1'b1);
    check({tag, ".adr"}, bus.W_Adr, dest);
    check({tag, ".W"}, bus.W, w);
    check({tag, ".N"}, bus.N, w[15]);
    check({tag, ".Z"}, bus.Z, w == 16'h0);
    check({tag, ".C"}, bus.C, c);
    check({tag, ".V"}, bus.V, v);
    sh_n = w[15]; sh_z = (w == 16'h0); sh_c = c; sh_v = v;
  endtask

  // Issue one op, scramble operands after issue, optionally poke start mid-iteration, then check.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [2:0] dest,
                        input logic [15:0] r, input logic [15:0] s, input bit noise);
    logic [15:0] w;
    logic c, v;
    bit legal;
    int lat, cyc, busy_cnt;
    ref_model(op, r, s, w, c, v, legal, lat);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.dest = dest; bus.R = r; bus.S = s;
    @(negedge clk);
    bus.start = 1'b0; bus.R = 16'($urandom); bus.S = 16'($urandom);
    cyc = 1; busy_cnt = 0;
    while (!bus.we && !bus.err && cyc < 40) begin
      if (bus.busy) busy_cnt++;
      if (noise && cyc == 5) begin
        bus.start = 1'b1; bus.op = 4'($urandom); bus.dest = 3'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check({tag, ".lat"}, cyc, lat);
    check({tag, ".busycyc"}, busy_cnt, (lat == 17) ? 16 : 0);
    check({tag, ".busy"}, bus.busy, 1'b0);
    if (legal) begin
      check({tag, ".err"}, bus.err, 1'b0);
      expect_wb(tag, dest, w, c, v);
    end else begin
      check({tag, ".err"}, bus.err, 1'b1);
      check({tag, ".we"}, bus.we, 1'b0);
      check({tag, ".flags"}, {bus.N, bus.Z, bus.C, bus.V}, {sh_n, sh_z, sh_c, sh_v});
    end
    @(negedge clk);
    check({tag, ".we_off"}, bus.we, 1'b0);
    check({tag, ".err_off"}, bus.err, 1'b0);
  endtask

  initial begin
    int we_seen;
    logic [3:0] rop;
    logic [15:0] rr, rs;
    bus.start = 1'b0; bus.op = '0; bus.dest = '0; bus.R = '0; bus.S = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.outs", {bus.busy, bus.we, bus.err, bus.N, bus.Z, bus.C, bus.V}, 7'b0);
    check("rst.W", bus.W, 16'h0);
    check("rst.adr", bus.W_Adr, 3'h0);
    reset = 1'b1;

    run_op("add_ovf", 4'h1, 3'd3, 16'h7FFF, 16'h0001, 1'b0);
    run_op("sub_zero", 4'h2, 3'd1, 16'h0005, 16'h0005, 1'b0);
    run_op("sub_borrow", 4'h2, 3'd2, 16'h0003, 16'h0005, 1'b0);
    run_op("add_carry", 4'h1, 3'd4, 16'hFFFF, 16'h0001, 1'b0);
    run_op("shl", 4'h7, 3'd0, 16'h8001, 16'h0000, 1'b0);
    run_op("shr", 4'h8, 3'd7, 16'h8001, 16'h0000, 1'b0);
    run_op("mul", 4'h9, 3'd5, 16'h0123, 16'h0100, 1'b1);
    run_op("mul_max", 4'h9, 3'd6, 16'hFFFF, 16'hFFFF, 1'b0);
    run_op("div", 4'hA, 3'd2, 16'h0064, 16'h0007, 1'b1);
    run_op("div0", 4'hA, 3'd2, 16'h1234, 16'h0000, 1'b0);
    run_op("ill_f", 4'hF, 3'd1, 16'h1111, 16'h2222, 1'b0);

    // Back-to-back: PASS issued in the WB cycle of an AND.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'h3; bus.dest = 3'd1; bus.R = 16'hF0F0; bus.S = 16'h0FF0;
    @(negedge clk);
    expect_wb("b2b.and", 3'd1, 16'h00F0, 1'b0, 1'b0);
    bus.op = 4'h0; bus.dest = 3'd6; bus.R = 16'h8421;
    @(negedge clk);
    bus.start = 1'b0;
    expect_wb("b2b.pass", 3'd6, 16'h8421, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b.we_off", bus.we, 1'b0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'h9; bus.dest = 3'd3; bus.R = 16'h00FF; bus.S = 16'h00FF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("mr.busy_pre", bus.busy, 1'b1);
    reset = 1'b0;
    #1;
    check("mr.busy", bus.busy, 1'b0);
    check("mr.we", bus.we, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    sh_n = 1'b0; sh_z = 1'b0; sh_c = 1'b0; sh_v = 1'b0;
    we_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.we || bus.busy) we_seen++;
    end
    check("mr.quiet", we_seen, 0);
    run_op("mr.add", 4'h1, 3'd2, 16'h1234, 16'h4321, 1'b0);

    for (int i = 0; i < 80; i++) begin
      rop = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      rs = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom >> $urandom_range(0, 12));
      run_op("rnd", rop, 3'($urandom), rr, rs, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
